// File: rtl/dio_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dio_seq_pkg
//  Description : Shared types and constants for the DIO pattern sequencer.
//                Holds the sequencer state encoding, the table entry layout
//                for the default dwell width, and the DIO mode codes carried
//                in cfg[15:14].
//  Revision    : 1.0 - initial release
// ============================================================================
package dio_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_HOLD  = 2'd2,
      ST_DONE  = 2'd3
   } dio_seq_state_t;

   localparam int DIO_SEQ_HOLD_W = 16;

   // Entry layout as written through tbl_wdata: {hold, cfg}.
   typedef struct packed {
      logic [DIO_SEQ_HOLD_W-1:0] hold;
      logic [15:0]               cfg;
   } dio_seq_entry_t;

   // DIO pin mode codes found in cfg[15:14].
   localparam logic [1:0] MODE_HIZ    = 2'b00;
   localparam logic [1:0] MODE_LOW    = 2'b01;
   localparam logic [1:0] MODE_HIGH   = 2'b10;
   localparam logic [1:0] MODE_CUSTOM = 2'b11;

endpackage
`default_nettype wire

// File: rtl/dio_seq_table.sv
`default_nettype none
// ============================================================================
//  Module      : dio_seq_table
//  Description : DEPTH x W register file for the sequencer entries.
//                One synchronous write port, one combinational read port.
//                Contents clear on reset and are otherwise retained.
//  Ports       : clk, rst_n       clock, async active-low reset
//                we, waddr, wdata write port (already gated by the caller)
//                raddr, rdata     combinational read port
//  Revision    : 1.0 - initial release
// ============================================================================
module dio_seq_table
   import dio_seq_pkg::*;
#(
   parameter  int DEPTH = 16,
   parameter  int W     = 32,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic [AW-1:0] raddr,
   output logic [W-1:0]  rdata
);

   logic [W-1:0] mem_q [DEPTH];

   for (genvar i = 0; i < DEPTH; i++) begin : g_entry
      logic [W-1:0] entry_d;

      always_comb begin
         entry_d = mem_q[i];
         if (we && (waddr == AW'(i))) begin
            entry_d = wdata;
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            mem_q[i] <= '0;
         end else begin
            mem_q[i] <= entry_d;
         end
      end
   end

   // DEPTH is a power of two, so every raddr value names a real entry.
   assign rdata = mem_q[raddr];

endmodule
`default_nettype wire

// File: rtl/dio_pattern_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : dio_pattern_sequencer
//  Description : Plays a table of timed config words onto the DIO config
//                port. Each entry is issued as a one-cycle cfg_en write,
//                followed by a dwell of max(hold,1) cycles before the next
//                entry. Optional wrap back to entry 0 after last_idx.
//  Ports       : clk, rst_n                   clock, async active-low reset
//                tbl_we/tbl_addr/tbl_wdata    host table write {hold, cfg}
//                tbl_err                      pulse: write rejected (busy)
//                start, stop, loop_en         sequence control
//                last_idx                     final entry (latched at start)
//                cfg_en, cfg_data             DIO config write port
//                busy, done, cur_idx          status
//  Revision    : 1.0 - initial release
// ============================================================================
module dio_pattern_sequencer
   import dio_seq_pkg::*;
#(
   parameter  int DEPTH  = 16,
   parameter  int HOLD_W = 16,
   localparam int AW     = $clog2(DEPTH)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               tbl_we,
   input  logic [AW-1:0]      tbl_addr,
   input  logic [HOLD_W+15:0] tbl_wdata,
   output logic               tbl_err,
   input  logic               start,
   input  logic               stop,
   input  logic               loop_en,
   input  logic [AW-1:0]      last_idx,
   output logic               cfg_en,
   output logic [15:0]        cfg_data,
   output logic               busy,
   output logic               done,
   output logic [AW-1:0]      cur_idx
);

   dio_seq_state_t     state_q, state_d;
   logic [AW-1:0]      idx_q, idx_d;
   logic [AW-1:0]      last_q, last_d;
   logic [HOLD_W-1:0]  cnt_q, cnt_d;
   logic [HOLD_W-1:0]  hold_q, hold_d;
   logic               cfg_en_q, cfg_en_d;
   logic [15:0]        cfg_data_q, cfg_data_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               tbl_err_q, tbl_err_d;
   logic [AW-1:0]      cur_idx_q, cur_idx_d;

   logic               w_advance;
   logic               w_issue;
   logic               w_tbl_open;
   logic [HOLD_W+15:0] w_rd_entry;

   // The table may only change while no sequence is in flight.
   assign w_tbl_open = (state_q == ST_IDLE) || (state_q == ST_DONE);

   // Read port follows idx_d so the entry about to be issued is captured
   // into the output registers on the same edge that enters ISSUE.
   dio_seq_table #(
      .DEPTH (DEPTH),
      .W     (HOLD_W + 16)
   ) u_table (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (tbl_we && w_tbl_open),
      .waddr (tbl_addr),
      .wdata (tbl_wdata),
      .raddr (idx_d),
      .rdata (w_rd_entry)
   );

   // Next-state logic. The dwell of the issued entry comes from hold_q,
   // which was captured alongside cfg_data, so no second read port is needed.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      last_d    = last_q;
      cnt_d     = cnt_q;
      w_advance = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start && !stop) begin
               state_d = ST_ISSUE;
               idx_d   = '0;
               last_d  = last_idx;
            end
         end
         ST_ISSUE: begin
            if (stop) begin
               state_d = ST_IDLE;
            end else if (hold_q > HOLD_W'(1)) begin
               // The ISSUE cycle and the final HOLD cycle both count
               // toward the dwell, hence h-2.
               cnt_d   = hold_q - HOLD_W'(2);
               state_d = ST_HOLD;
            end else begin
               w_advance = 1'b1;
            end
         end
         ST_HOLD: begin
            if (stop) begin
               state_d = ST_IDLE;
            end else if (cnt_q == '0) begin
               w_advance = 1'b1;
            end else begin
               cnt_d = cnt_q - HOLD_W'(1);
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (w_advance) begin
         if (idx_q != last_q) begin
            idx_d   = idx_q + AW'(1);
            state_d = ST_ISSUE;
         end else if (loop_en) begin
            idx_d   = '0;
            state_d = ST_ISSUE;
         end else begin
            state_d = ST_DONE;
         end
      end
   end

   // Outputs are registered from the next state so they line up with it.
   always_comb begin
      w_issue    = (state_d == ST_ISSUE);
      cfg_en_d   = w_issue;
      cfg_data_d = w_issue ? w_rd_entry[15:0] : cfg_data_q;
      hold_d     = w_issue ? w_rd_entry[HOLD_W+15:16] : hold_q;
      cur_idx_d  = w_issue ? idx_d : cur_idx_q;
      busy_d     = (state_d == ST_ISSUE) || (state_d == ST_HOLD);
      done_d     = (state_d == ST_DONE);
      tbl_err_d  = tbl_we && !w_tbl_open;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         idx_q      <= '0;
         last_q     <= '0;
         cnt_q      <= '0;
         hold_q     <= '0;
         cfg_en_q   <= 1'b0;
         cfg_data_q <= 16'h0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         tbl_err_q  <= 1'b0;
         cur_idx_q  <= '0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         last_q     <= last_d;
         cnt_q      <= cnt_d;
         hold_q     <= hold_d;
         cfg_en_q   <= cfg_en_d;
         cfg_data_q <= cfg_data_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         tbl_err_q  <= tbl_err_d;
         cur_idx_q  <= cur_idx_d;
      end
   end

   assign cfg_en   = cfg_en_q;
   assign cfg_data = cfg_data_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign tbl_err  = tbl_err_q;
   assign cur_idx  = cur_idx_q;

endmodule
`default_nettype wire
